// File: rtl/bp_io_cce_tracked.sv
// Uncached I/O coherence engine: buffers LCE uncached requests into I/O memory commands under an
// outstanding-command credit limit, and turns I/O responses back into LCE commands.
module bp_io_cce_tracked
    #(parameter int paddr_width_p     = 40
    , parameter int cce_block_width_p = 64
    , parameter int lce_id_width_p    = 4
    , parameter int cce_id_width_p    = 4
    , parameter int max_outstanding_p = 8
    , parameter int req_fifo_els_p    = 2
    , parameter int resp_fifo_els_p   = 2
    , localparam int lce_cce_req_width_lp = 3 + lce_id_width_p + 3 + paddr_width_p + cce_block_width_p
    , localparam int cce_mem_msg_width_lp = 4 + 3 + paddr_width_p + lce_id_width_p + 1 + cce_block_width_p
    , localparam int lce_cmd_width_lp     = 4 + lce_id_width_p + cce_id_width_p + 3 + paddr_width_p + cce_block_width_p
    , localparam int cnt_width_lp         = $clog2(max_outstanding_p + 1)
    )
    (input  logic                            clk_i
    , input  logic                            reset_i
    , input  logic [cce_id_width_p-1:0]       cce_id_i
    , input  logic [lce_cce_req_width_lp-1:0] lce_req_i
    , input  logic                            lce_req_v_i
    , output logic                            lce_req_yumi_o
    , output logic [lce_cmd_width_lp-1:0]     lce_cmd_o
    , output logic                            lce_cmd_v_o
    , input  logic                            lce_cmd_ready_i
    , output logic [cce_mem_msg_width_lp-1:0] io_cmd_o
    , output logic                            io_cmd_v_o
    , input  logic                            io_cmd_ready_i
    , input  logic [cce_mem_msg_width_lp-1:0] io_resp_i
    , input  logic                            io_resp_v_i
    , output logic                            io_resp_yumi_o
    , output logic [cnt_width_lp-1:0]         outstanding_o
    , output logic                            idle_o
    , output logic                            error_o
    );

    localparam logic [2:0] req_rd_lp       = 3'd0;
    localparam logic [2:0] req_uc_rd_lp    = 3'd2;
    localparam logic [2:0] req_uc_wr_lp    = 3'd3;
    localparam logic [3:0] mem_uc_rd_lp    = 4'd2;
    localparam logic [3:0] mem_uc_wr_lp    = 4'd3;
    localparam logic [3:0] cmd_uc_data_lp  = 4'd9;
    localparam logic [3:0] cmd_uc_done_lp  = 4'd10;

    localparam int req_aw_lp  = $clog2(req_fifo_els_p);
    localparam int resp_aw_lp = $clog2(resp_fifo_els_p);
    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_outstanding_p);

    typedef struct packed {
        logic [2:0]                   msg_type;
        logic [lce_id_width_p-1:0]    src_id;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } lce_req_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
        logic                      uncached;
    } mem_payload_s;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        mem_payload_s                 payload;
        logic [cce_block_width_p-1:0] data;
    } mem_msg_s;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [lce_id_width_p-1:0]    dst_id;
        logic [cce_id_width_p-1:0]    src_id;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } lce_cmd_s;

    // Pointers carry a wrap bit above the index so full and empty are distinguishable.
    function automatic logic [req_aw_lp:0] req_ptr_inc(input logic [req_aw_lp:0] p);
        if (p[req_aw_lp-1:0] == req_aw_lp'(req_fifo_els_p - 1))
            return {~p[req_aw_lp], {req_aw_lp{1'b0}}};
        return {p[req_aw_lp], p[req_aw_lp-1:0] + req_aw_lp'(1)};
    endfunction

    function automatic logic [resp_aw_lp:0] resp_ptr_inc(input logic [resp_aw_lp:0] p);
        if (p[resp_aw_lp-1:0] == resp_aw_lp'(resp_fifo_els_p - 1))
            return {~p[resp_aw_lp], {resp_aw_lp{1'b0}}};
        return {p[resp_aw_lp], p[resp_aw_lp-1:0] + resp_aw_lp'(1)};
    endfunction

    logic [req_aw_lp:0]      req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [resp_aw_lp:0]     resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    error_q, error_d;

    lce_req_s req_mem_q  [req_fifo_els_p];
    mem_msg_s resp_mem_q [resp_fifo_els_p];

    lce_req_s req_in, req_head;
    mem_msg_s resp_in, resp_head, io_cmd;
    lce_cmd_s lce_cmd;
    logic     req_full, req_empty, resp_full, resp_empty;
    logic     req_is_uc, req_enq, io_cmd_hs, lce_cmd_hs;

    assign req_in  = lce_req_i;
    assign resp_in = io_resp_i;

    assign req_full   = (req_wr_q[req_aw_lp-1:0] == req_rd_q[req_aw_lp-1:0])
                      && (req_wr_q[req_aw_lp] != req_rd_q[req_aw_lp]);
    assign req_empty  = (req_wr_q == req_rd_q);
    assign resp_full  = (resp_wr_q[resp_aw_lp-1:0] == resp_rd_q[resp_aw_lp-1:0])
                      && (resp_wr_q[resp_aw_lp] != resp_rd_q[resp_aw_lp]);
    assign resp_empty = (resp_wr_q == resp_rd_q);

    assign req_is_uc      = (req_in.msg_type == req_uc_rd_lp) || (req_in.msg_type == req_uc_wr_lp);
    assign lce_req_yumi_o = lce_req_v_i & ~req_full & ~reset_i;
    assign req_enq        = lce_req_yumi_o & req_is_uc;

    assign io_cmd_v_o     = ~req_empty & (cnt_q < max_cnt_lp);
    assign io_cmd_hs      = io_cmd_v_o & io_cmd_ready_i;

    assign io_resp_yumi_o = io_resp_v_i & ~resp_full & ~reset_i;
    assign lce_cmd_v_o    = ~resp_empty;
    assign lce_cmd_hs     = lce_cmd_v_o & lce_cmd_ready_i;

    assign outstanding_o  = cnt_q;
    assign idle_o         = req_empty & resp_empty & (cnt_q == '0);
    assign error_o        = error_q;

    always_comb begin
        req_wr_d  = req_enq    ? req_ptr_inc(req_wr_q)   : req_wr_q;
        req_rd_d  = io_cmd_hs  ? req_ptr_inc(req_rd_q)   : req_rd_q;
        resp_wr_d = io_resp_yumi_o ? resp_ptr_inc(resp_wr_q) : resp_wr_q;
        resp_rd_d = lce_cmd_hs ? resp_ptr_inc(resp_rd_q) : resp_rd_q;
        error_d   = error_q | (lce_req_yumi_o & ~req_is_uc);
        cnt_d     = cnt_q;
        // A response with nothing outstanding is still drained but must not wrap the count.
        if (io_cmd_hs && !io_resp_yumi_o)
            cnt_d = cnt_q + cnt_width_lp'(1);
        else if (!io_cmd_hs && io_resp_yumi_o && (cnt_q != '0))
            cnt_d = cnt_q - cnt_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            req_wr_q  <= '0;
            req_rd_q  <= '0;
            resp_wr_q <= '0;
            resp_rd_q <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            req_wr_q  <= req_wr_d;
            req_rd_q  <= req_rd_d;
            resp_wr_q <= resp_wr_d;
            resp_rd_q <= resp_rd_d;
            cnt_q     <= cnt_d;
            error_q   <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_enq)
            req_mem_q[req_wr_q[req_aw_lp-1:0]] <= req_in;
        if (io_resp_yumi_o)
            resp_mem_q[resp_wr_q[resp_aw_lp-1:0]] <= resp_in;
    end

    always_comb begin
        req_head                = req_mem_q[req_rd_q[req_aw_lp-1:0]];
        io_cmd                  = '0;
        io_cmd.msg_type         = (req_head.msg_type == req_uc_wr_lp) ? mem_uc_wr_lp : mem_uc_rd_lp;
        io_cmd.size             = req_head.size;
        io_cmd.addr             = req_head.addr;
        io_cmd.payload.lce_id   = req_head.src_id;
        io_cmd.payload.uncached = 1'b1;
        io_cmd.data             = req_head.data;
    end

    always_comb begin
        resp_head      = resp_mem_q[resp_rd_q[resp_aw_lp-1:0]];
        lce_cmd        = '0;
        lce_cmd.dst_id = resp_head.payload.lce_id;
        lce_cmd.src_id = cce_id_i;
        lce_cmd.addr   = resp_head.addr;
        if (resp_head.msg_type == mem_uc_wr_lp) begin
            lce_cmd.msg_type = cmd_uc_done_lp;
        end else begin
            lce_cmd.msg_type = cmd_uc_data_lp;
            lce_cmd.size     = resp_head.size;
            lce_cmd.data     = resp_head.data;
        end
    end

    assign io_cmd_o  = io_cmd;
    assign lce_cmd_o = lce_cmd;

    logic unused_rd_type;
    assign unused_rd_type = (req_rd_lp == 3'd0);

endmodule

// File: tb/tb_bp_io_cce_tracked.sv
// Directed bench for bp_io_cce_tracked: uncached read/write round trips, credit limit,
// counter boundaries, unsupported-type rejection, response back-pressure and mid-stream reset.
`timescale 1ns/1ps
module tb_bp_io_cce_tracked;

    localparam int PA = 40, DW = 64, LW = 4, CW = 4, CNT_W = 4;
    localparam int REQ_W = 3 + LW + 3 + PA + DW;
    localparam int MEM_W = 4 + 3 + PA + LW + 1 + DW;
    localparam int CMD_W = 4 + LW + CW + 3 + PA + DW;

    localparam logic [2:0] REQ_RD = 3'd0, REQ_UC_RD = 3'd2, REQ_UC_WR = 3'd3;
    localparam logic [3:0] MEM_UC_RD = 4'd2, MEM_UC_WR = 4'd3;
    localparam logic [3:0] CMD_UC_DATA = 4'd9, CMD_UC_DONE = 4'd10;
    localparam logic [CW-1:0] CCE_ID = 4'h5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i = 1'b1;
    logic [CW-1:0]     cce_id_i = CCE_ID;
    logic [REQ_W-1:0]  lce_req_i = '0;
    logic              lce_req_v_i = 1'b0;
    logic              lce_req_yumi_o;
    logic [CMD_W-1:0]  lce_cmd_o;
    logic              lce_cmd_v_o;
    logic              lce_cmd_ready_i = 1'b0;
    logic [MEM_W-1:0]  io_cmd_o;
    logic              io_cmd_v_o;
    logic              io_cmd_ready_i = 1'b0;
    logic [MEM_W-1:0]  io_resp_i = '0;
    logic              io_resp_v_i = 1'b0;
    logic              io_resp_yumi_o;
    logic [CNT_W-1:0]  outstanding_o;
    logic              idle_o;
    logic              error_o;

    int vecs = 0;
    int errs = 0;

    bp_io_cce_tracked #(
        .paddr_width_p(PA), .cce_block_width_p(DW), .lce_id_width_p(LW), .cce_id_width_p(CW),
        .max_outstanding_p(8), .req_fifo_els_p(2), .resp_fifo_els_p(2)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .cce_id_i(cce_id_i),
        .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_yumi_o(lce_req_yumi_o),
        .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
        .outstanding_o(outstanding_o), .idle_o(idle_o), .error_o(error_o)
    );

    function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [LW-1:0] src,
                                                input logic [2:0] sz, input logic [PA-1:0] a,
                                                input logic [DW-1:0] d);
        return {t, src, sz, a, d};
    endfunction

    function automatic logic [MEM_W-1:0] mk_mem(input logic [3:0] t, input logic [2:0] sz,
                                                input logic [PA-1:0] a, input logic [LW-1:0] lce,
                                                input logic unc, input logic [DW-1:0] d);
        return {t, sz, a, lce, unc, d};
    endfunction

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [3:0] t, input logic [LW-1:0] dst,
                                                input logic [CW-1:0] src, input logic [2:0] sz,
                                                input logic [PA-1:0] a, input logic [DW-1:0] d);
        return {t, dst, src, sz, a, d};
    endfunction

    task automatic clear_inputs();
        lce_req_v_i     = 1'b0;
        io_resp_v_i     = 1'b0;
        io_cmd_ready_i  = 1'b0;
        lce_cmd_ready_i = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        lce_req_i   = mk_req(REQ_UC_RD, 4'd1, 3'd3, 40'h40, 64'd0);
        lce_req_v_i = 1'b1;
        io_resp_v_i = 1'b1;
        #1;
        vecs++; if (lce_req_yumi_o !== 1'b0) begin errs++; $display("FAIL reset_req_yumi got %b exp 0", lce_req_yumi_o); end
        vecs++; if (io_resp_yumi_o !== 1'b0) begin errs++; $display("FAIL reset_resp_yumi got %b exp 0", io_resp_yumi_o); end
        vecs++; if (io_cmd_v_o !== 1'b0) begin errs++; $display("FAIL reset_io_cmd_v got %b exp 0", io_cmd_v_o); end
        vecs++; if (lce_cmd_v_o !== 1'b0) begin errs++; $display("FAIL reset_lce_cmd_v got %b exp 0", lce_cmd_v_o); end
        vecs++; if (idle_o !== 1'b1) begin errs++; $display("FAIL reset_idle got %b exp 1", idle_o); end
        vecs++; if (error_o !== 1'b0) begin errs++; $display("FAIL reset_error got %b exp 0", error_o); end
        vecs++; if (outstanding_o !== 4'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", outstanding_o); end
        @(negedge clk);
        clear_inputs();
        reset_i = 1'b0;
    endtask

    task automatic test_uc_rd();
        logic [MEM_W-1:0] exp_io;
        logic [CMD_W-1:0] exp_cmd;
        apply_reset();
        exp_io  = mk_mem(MEM_UC_RD, 3'd3, 40'h80000040, 4'd2, 1'b1, 64'd0);
        exp_cmd = mk_cmd(CMD_UC_DATA, 4'd2, CCE_ID, 3'd3, 40'h80000040, 64'hDEADBEEF);
        lce_req_i   = mk_req(REQ_UC_RD, 4'd2, 3'd3, 40'h80000040, 64'd0);
        lce_req_v_i = 1'b1;
        #1;
        vecs++; if (lce_req_yumi_o !== 1'b1) begin errs++; $display("FAIL rd_yumi got %b exp 1", lce_req_yumi_o); end
        vecs++; if (io_cmd_v_o !== 1'b0) begin errs++; $display("FAIL rd_no_bypass got %b exp 0", io_cmd_v_o); end
        @(negedge clk);
        lce_req_v_i = 1'b0;
        #1;
        vecs++; if (io_cmd_v_o !== 1'b1) begin errs++; $display("FAIL rd_io_cmd_v got %b exp 1", io_cmd_v_o); end
        vecs++; if (io_cmd_o !== exp_io) begin errs++; $display("FAIL rd_io_cmd got %h exp %h", io_cmd_o, exp_io); end
        vecs++; if (idle_o !== 1'b0) begin errs++; $display("FAIL rd_busy got %b exp 0", idle_o); end
        io_cmd_ready_i = 1'b1;
        @(negedge clk);
        io_cmd_ready_i = 1'b0;
        #1;
        vecs++; if (outstanding_o !== 4'd1) begin errs++; $display("FAIL rd_count_up got %0d exp 1", outstanding_o); end
        vecs++; if (io_cmd_v_o !== 1'b0) begin errs++; $display("FAIL rd_io_cmd_drained got %b exp 0", io_cmd_v_o); end
        io_resp_i   = mk_mem(MEM_UC_RD, 3'd3, 40'h80000040, 4'd2, 1'b1, 64'hDEADBEEF);
        io_resp_v_i = 1'b1;
        #1;
        vecs++; if (io_resp_yumi_o !== 1'b1) begin errs++; $display("FAIL rd_resp_yumi got %b exp 1", io_resp_yumi_o); end
        vecs++; if (lce_cmd_v_o !== 1'b0) begin errs++; $display("FAIL rd_resp_no_bypass got %b exp 0", lce_cmd_v_o); end
        @(negedge clk);
        io_resp_v_i = 1'b0;
        #1;
        vecs++; if (lce_cmd_v_o !== 1'b1) begin errs++; $display("FAIL rd_lce_cmd_v got %b exp 1", lce_cmd_v_o); end
        vecs++; if (lce_cmd_o !== exp_cmd) begin errs++; $display("FAIL rd_lce_cmd got %h exp %h", lce_cmd_o, exp_cmd); end
        vecs++; if (outstanding_o !== 4'd0) begin errs++; $display("FAIL rd_count_down got %0d exp 0", outstanding_o); end
        lce_cmd_ready_i = 1'b1;
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;
        #1;
        vecs++; if (lce_cmd_v_o !== 1'b0) begin errs++; $display("FAIL rd_lce_cmd_drained got %b exp 0", lce_cmd_v_o); end
        vecs++; if (idle_o !== 1'b1) begin errs++; $display("FAIL rd_idle got %b exp 1", idle_o); end
    endtask

    task automatic test_uc_wr();
        logic [MEM_W-1:0] exp_io;
        logic [CMD_W-1:0] exp_cmd;
        apply_reset();
        exp_io  = mk_mem(MEM_UC_WR, 3'd2, 40'h100, 4'd1, 1'b1, 64'h12345678);
        exp_cmd = mk_cmd(CMD_UC_DONE, 4'd1, CCE_ID, 3'd0, 40'h100, 64'd0);
        lce_req_i   = mk_req(REQ_UC_WR, 4'd1, 3'd2, 40'h100, 64'h12345678);
        lce_req_v_i = 1'b1;
        @(negedge clk);
        lce_req_v_i    = 1'b0;
        io_cmd_ready_i = 1'b1;
        #1;
        vecs++; if (io_cmd_o !== exp_io) begin errs++; $display("FAIL wr_io_cmd got %h exp %h", io_cmd_o, exp_io); end
        @(negedge clk);
        io_cmd_ready_i = 1'b0;
        io_resp_i      = mk_mem(MEM_UC_WR, 3'd2, 40'h100, 4'd1, 1'b1, 64'h5555);
        io_resp_v_i    = 1'b1;
        @(negedge clk);
        io_resp_v_i = 1'b0;
        #1;
        vecs++; if (lce_cmd_o !== exp_cmd) begin errs++; $display("FAIL wr_lce_cmd got %h exp %h", lce_cmd_o, exp_cmd); end
        lce_cmd_ready_i = 1'b1;
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;
    endtask

    task automatic test_credit();
        int   acc = 0;
        int   hs = 0;
        logic stalled = 1'b0;
        apply_reset();
        io_cmd_ready_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            lce_req_i   = mk_req(REQ_UC_RD, LW'(acc), 3'd3, PA'(acc * 64), 64'd0);
            lce_req_v_i = 1'b1;
            #1;
            if (lce_req_yumi_o) acc++;
            else stalled = 1'b1;
            if (io_cmd_v_o) hs++;
        end
        vecs++; if (hs !== 8) begin errs++; $display("FAIL credit_handshakes got %0d exp 8", hs); end
        vecs++; if (acc !== 10) begin errs++; $display("FAIL credit_accepted got %0d exp 10", acc); end
        vecs++; if (stalled !== 1'b1) begin errs++; $display("FAIL credit_req_stall got %b exp 1", stalled); end
        vecs++; if (outstanding_o !== 4'd8) begin errs++; $display("FAIL credit_count got %0d exp 8", outstanding_o); end
        vecs++; if (io_cmd_v_o !== 1'b0) begin errs++; $display("FAIL credit_gate got %b exp 0", io_cmd_v_o); end
        @(negedge clk);
        lce_req_v_i     = 1'b0;
        lce_cmd_ready_i = 1'b1;
        io_resp_i       = mk_mem(MEM_UC_RD, 3'd3, 40'h0, 4'd0, 1'b1, 64'd7);
        io_resp_v_i     = 1'b1;
        #1;
        vecs++; if (io_resp_yumi_o !== 1'b1) begin errs++; $display("FAIL credit_resp_yumi got %b exp 1", io_resp_yumi_o); end
        @(negedge clk);
        io_resp_v_i = 1'b0;
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (io_cmd_v_o) hs++;
            @(negedge clk);
        end
        vecs++; if (hs !== 1) begin errs++; $display("FAIL credit_one_more got %0d exp 1", hs); end
        vecs++; if (outstanding_o !== 4'd8) begin errs++; $display("FAIL credit_refill got %0d exp 8", outstanding_o); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        io_cmd_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            lce_req_i   = mk_req(REQ_UC_RD, 4'd3, 3'd3, PA'(c * 64), 64'd0);
            lce_req_v_i = (c < 5);
        end
        #1;
        vecs++; if (outstanding_o !== 4'd5) begin errs++; $display("FAIL same_count_pre got %0d exp 5", outstanding_o); end
        io_cmd_ready_i = 1'b0;
        lce_req_v_i    = 1'b1;
        @(negedge clk);
        lce_req_v_i    = 1'b0;
        io_cmd_ready_i = 1'b1;
        io_resp_i      = mk_mem(MEM_UC_RD, 3'd3, 40'h0, 4'd3, 1'b1, 64'd1);
        io_resp_v_i    = 1'b1;
        #1;
        vecs++; if ({io_cmd_v_o, io_resp_yumi_o} !== 2'b11) begin errs++; $display("FAIL same_both_hs got %b exp 11", {io_cmd_v_o, io_resp_yumi_o}); end
        @(negedge clk);
        io_resp_v_i    = 1'b0;
        io_cmd_ready_i = 1'b0;
        #1;
        vecs++; if (outstanding_o !== 4'd5) begin errs++; $display("FAIL same_count_post got %0d exp 5", outstanding_o); end
    endtask

    task automatic test_resp_at_zero();
        apply_reset();
        io_resp_i   = mk_mem(MEM_UC_RD, 3'd1, 40'h20, 4'd4, 1'b1, 64'd9);
        io_resp_v_i = 1'b1;
        #1;
        vecs++; if (io_resp_yumi_o !== 1'b1) begin errs++; $display("FAIL zero_resp_yumi got %b exp 1", io_resp_yumi_o); end
        @(negedge clk);
        io_resp_v_i = 1'b0;
        #1;
        vecs++; if (outstanding_o !== 4'd0) begin errs++; $display("FAIL zero_no_wrap got %0d exp 0", outstanding_o); end
        vecs++; if (lce_cmd_v_o !== 1'b1) begin errs++; $display("FAIL zero_lce_cmd_v got %b exp 1", lce_cmd_v_o); end
        lce_cmd_ready_i = 1'b1;
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;
        #1;
        vecs++; if (idle_o !== 1'b1) begin errs++; $display("FAIL zero_idle got %b exp 1", idle_o); end
    endtask

    task automatic test_cached_reject();
        apply_reset();
        io_cmd_ready_i = 1'b1;
        lce_req_i      = mk_req(REQ_RD, 4'd1, 3'd3, 40'h200, 64'd0);
        lce_req_v_i    = 1'b1;
        #1;
        vecs++; if (lce_req_yumi_o !== 1'b1) begin errs++; $display("FAIL cached_yumi got %b exp 1", lce_req_yumi_o); end
        @(negedge clk);
        lce_req_v_i = 1'b0;
        #1;
        vecs++; if (io_cmd_v_o !== 1'b0) begin errs++; $display("FAIL cached_no_cmd got %b exp 0", io_cmd_v_o); end
        vecs++; if (error_o !== 1'b1) begin errs++; $display("FAIL cached_error got %b exp 1", error_o); end
        vecs++; if (idle_o !== 1'b1) begin errs++; $display("FAIL cached_idle got %b exp 1", idle_o); end
        repeat (3) @(negedge clk);
        #1;
        vecs++; if (error_o !== 1'b1) begin errs++; $display("FAIL cached_sticky got %b exp 1", error_o); end
        apply_reset();
        #1;
        vecs++; if (error_o !== 1'b0) begin errs++; $display("FAIL cached_cleared got %b exp 0", error_o); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] dat [3];
        logic [CMD_W-1:0] exp_cmd [3];
        dat[0] = 64'hAAAA0001;
        dat[1] = 64'hBBBB0002;
        dat[2] = 64'hCCCC0003;
        for (int i = 0; i < 3; i++)
            exp_cmd[i] = mk_cmd(CMD_UC_DATA, LW'(i + 1), CCE_ID, 3'd3, PA'(i * 16), dat[i]);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            io_resp_i   = mk_mem(MEM_UC_RD, 3'd3, PA'(i * 16), LW'(i + 1), 1'b1, dat[i]);
            io_resp_v_i = 1'b1;
            #1;
            vecs++; if (io_resp_yumi_o !== (i < 2)) begin errs++; $display("FAIL bp_yumi%0d got %b exp %b", i, io_resp_yumi_o, (i < 2)); end
        end
        @(negedge clk);
        lce_cmd_ready_i = 1'b1;
        #1;
        vecs++; if (lce_cmd_o !== exp_cmd[0]) begin errs++; $display("FAIL bp_first got %h exp %h", lce_cmd_o, exp_cmd[0]); end
        vecs++; if (io_resp_yumi_o !== 1'b0) begin errs++; $display("FAIL bp_no_bypass got %b exp 0", io_resp_yumi_o); end
        @(negedge clk);
        #1;
        vecs++; if (lce_cmd_o !== exp_cmd[1]) begin errs++; $display("FAIL bp_second got %h exp %h", lce_cmd_o, exp_cmd[1]); end
        vecs++; if (io_resp_yumi_o !== 1'b1) begin errs++; $display("FAIL bp_third_yumi got %b exp 1", io_resp_yumi_o); end
        @(negedge clk);
        io_resp_v_i = 1'b0;
        #1;
        vecs++; if (lce_cmd_o !== exp_cmd[2]) begin errs++; $display("FAIL bp_third got %h exp %h", lce_cmd_o, exp_cmd[2]); end
        @(negedge clk);
        #1;
        vecs++; if (lce_cmd_v_o !== 1'b0) begin errs++; $display("FAIL bp_empty got %b exp 0", lce_cmd_v_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        lce_req_i   = mk_req(REQ_UC_RD, 4'd6, 3'd3, 40'h300, 64'd0);
        lce_req_v_i = 1'b1;
        @(negedge clk);
        lce_req_v_i = 1'b0;
        io_resp_i   = mk_mem(MEM_UC_RD, 3'd3, 40'h300, 4'd6, 1'b1, 64'd5);
        io_resp_v_i = 1'b1;
        @(negedge clk);
        #1;
        vecs++; if ({io_cmd_v_o, lce_cmd_v_o, idle_o} !== 3'b110) begin errs++; $display("FAIL mid_busy got %b exp 110", {io_cmd_v_o, lce_cmd_v_o, idle_o}); end
        lce_req_v_i = 1'b1;
        reset_i     = 1'b1;
        #1;
        vecs++; if ({io_cmd_v_o, lce_cmd_v_o} !== 2'b00) begin errs++; $display("FAIL mid_valids got %b exp 00", {io_cmd_v_o, lce_cmd_v_o}); end
        vecs++; if ({lce_req_yumi_o, io_resp_yumi_o} !== 2'b00) begin errs++; $display("FAIL mid_yumis got %b exp 00", {lce_req_yumi_o, io_resp_yumi_o}); end
        vecs++; if (idle_o !== 1'b1) begin errs++; $display("FAIL mid_idle got %b exp 1", idle_o); end
        @(negedge clk);
        clear_inputs();
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors %0d", vecs);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_uc_rd();
        test_uc_wr();
        test_credit();
        test_same_cycle();
        test_resp_at_zero();
        test_cached_reject();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
